// File: rtl/streamer_seq_ctrl.sv
// Sequencer that drives a streamer through clear / store / load phases
// and watches for completion, with an optional per-phase wait timeout.
module streamer_seq_ctrl #(
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [1:0]               i_cmd_op,
    input  logic [TIMEOUT_WIDTH-1:0] i_cmd_timeout,
    output logic                     o_str_store_reset,
    output logic                     o_str_load_reset,
    output logic                     o_str_store_init,
    output logic                     o_str_load_init,
    input  logic                     i_str_fin_store,
    input  logic                     i_ld_tvalid,
    input  logic                     i_ld_tready,
    input  logic                     i_ld_tlast,
    output logic                     o_done,
    output logic                     o_err_timeout,
    output logic                     o_busy,
    output logic [2:0]               o_state_dbg,
    output logic [7:0]               o_op_count,
    output logic [TIMEOUT_WIDTH-1:0] o_wait_cycles
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLR_ST  = 3'd1,
        CLR_LD  = 3'd2,
        ST_RST  = 3'd3,
        ST_INIT = 3'd4,
        ST_WAIT = 3'd5,
        LD_INIT = 3'd6,
        LD_WAIT = 3'd7
    } state_t;

    localparam logic [1:0] OP_CLEAR      = 2'b00;
    localparam logic [1:0] OP_STORE      = 2'b01;
    localparam logic [1:0] OP_LOAD       = 2'b10;
    localparam logic [1:0] OP_STORE_LOAD = 2'b11;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [1:0]               r_op;
    logic [TIMEOUT_WIDTH-1:0] r_timeout;
    logic [TIMEOUT_WIDTH-1:0] r_tmo_cnt;
    logic [TIMEOUT_WIDTH-1:0] r_wait_cycles;
    logic [7:0]               r_op_count;
    logic                     r_done;
    logic                     r_err_timeout;

    logic w_accept;
    logic w_in_wait;
    logic w_complete;
    logic w_expire;
    logic w_finish;

    assign w_accept   = i_cmd_valid && (r_state == IDLE);
    assign w_in_wait  = (r_state == ST_WAIT) || (r_state == LD_WAIT);
    assign w_complete = ((r_state == ST_WAIT) && i_str_fin_store) ||
                        ((r_state == LD_WAIT) && i_ld_tvalid && i_ld_tready && i_ld_tlast);
    // Completion wins over expiry when both land in the same cycle.
    assign w_expire   = w_in_wait && !w_complete && (r_timeout != '0) &&
                        (r_tmo_cnt == TIMEOUT_WIDTH'(1));
    assign w_finish   = (r_state != IDLE) && (w_next_state == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (i_cmd_valid) begin
                    case (i_cmd_op)
                        OP_CLEAR: w_next_state = CLR_ST;
                        OP_LOAD:  w_next_state = CLR_LD;
                        default:  w_next_state = ST_RST;
                    endcase
                end
            end
            CLR_ST:  w_next_state = CLR_LD;
            CLR_LD:  w_next_state = (r_op == OP_CLEAR) ? IDLE : LD_INIT;
            ST_RST:  w_next_state = ST_INIT;
            ST_INIT: w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (i_str_fin_store) begin
                    w_next_state = (r_op == OP_STORE_LOAD) ? CLR_LD : IDLE;
                end else if (w_expire) begin
                    w_next_state = IDLE;
                end
            end
            LD_INIT: w_next_state = LD_WAIT;
            LD_WAIT: begin
                if (w_complete || w_expire) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        o_str_store_reset = 1'b0;
        o_str_load_reset  = 1'b0;
        o_str_store_init  = 1'b0;
        o_str_load_init   = 1'b0;
        case (r_state)
            CLR_ST, ST_RST: o_str_store_reset = 1'b1;
            CLR_LD:         o_str_load_reset  = 1'b1;
            ST_INIT:        o_str_store_init  = 1'b1;
            LD_INIT:        o_str_load_init   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op      <= OP_CLEAR;
            r_timeout <= '0;
        end else if (w_accept) begin
            r_op      <= i_cmd_op;
            r_timeout <= i_cmd_timeout;
        end
    end

    // The init state always precedes its wait state, so it is the load point.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ST_INIT) || (r_state == LD_INIT)) begin
            r_tmo_cnt <= r_timeout;
        end else if (w_in_wait && !w_complete && (r_timeout != '0)) begin
            r_tmo_cnt <= r_tmo_cnt - TIMEOUT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cycles <= '0;
        end else if (w_accept) begin
            r_wait_cycles <= '0;
        end else if (w_in_wait && (r_wait_cycles != {TIMEOUT_WIDTH{1'b1}})) begin
            r_wait_cycles <= r_wait_cycles + TIMEOUT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_op_count    <= 8'd0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_err_timeout <= 1'b0;
            end else if (w_expire) begin
                r_err_timeout <= 1'b1;
            end
            if (w_finish && !w_expire) begin
                r_op_count <= r_op_count + 8'd1;
            end
        end
    end

    assign o_cmd_ready   = (r_state == IDLE);
    assign o_busy        = (r_state != IDLE);
    assign o_state_dbg   = r_state;
    assign o_done        = r_done;
    assign o_err_timeout = r_err_timeout;
    assign o_op_count    = r_op_count;
    assign o_wait_cycles = r_wait_cycles;

endmodule

// File: doc/streamer_seq_ctrl.md
STREAMER_SEQ_CTRL -- requirements
Module: streamer_seq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_WIDTH, default 16, width of the timeout value and the wait-cycle counter.
REQ-002 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  in  1  command request.
REQ-005 SHALL have port cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-006 SHALL have port cmd_op  in  2  operation: 00 CLEAR, 01 STORE, 10 LOAD, 11 STORE_LOAD.
REQ-007 SHALL have port cmd_timeout  in  TIMEOUT_WIDTH  maximum wait cycles per phase; 0 disables the timeout.
REQ-008 SHALL have port str_store_reset  out  1  store-pointer clear pulse to the streamer.
REQ-009 SHALL have port str_load_reset  out  1  load-pointer clear pulse to the streamer.
REQ-010 SHALL have port str_store_init  out  1  store start pulse to the streamer.
REQ-011 SHALL have port str_load_init  out  1  load start pulse to the streamer.
REQ-012 SHALL have port str_fin_store  in  1  level store-complete flag from the streamer.
REQ-013 SHALL have ports ld_tvalid, ld_tready, ld_tlast  in  1 each  monitor taps of the streamer load-side AXIS.
REQ-014 SHALL have port done  out  1  one-cycle command-complete pulse.
REQ-015 SHALL have port err_timeout  out  1  sticky timeout flag.
REQ-016 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-017 SHALL have ports state_dbg  out  3  current state encoding; op_count  out  8  completed-command count; wait_cycles  out  TIMEOUT_WIDTH  wait-cycle count of the current/last command.

Function
REQ-018 SHALL implement states IDLE=0, CLR_ST=1, CLR_LD=2, ST_RST=3, ST_INIT=4, ST_WAIT=5, LD_INIT=6, LD_WAIT=7; LD_RST is shared with CLR_LD.
REQ-019 SHALL drive cmd_ready = (state==IDLE), combinationally from the state register only.
REQ-020 SHALL latch cmd_op and cmd_timeout on acceptance; later input changes have no effect until the next acceptance.
REQ-021 SHALL transition on acceptance: CLEAR->CLR_ST, STORE or STORE_LOAD->ST_RST, LOAD->CLR_LD.
REQ-022 SHALL drive str_store_reset high only in CLR_ST and ST_RST, str_load_reset only in CLR_LD, str_store_init only in ST_INIT, str_load_init only in LD_INIT; never two strobes in one cycle.
REQ-023 SHALL sequence CLR_ST->CLR_LD unconditionally; from CLR_LD go IDLE for CLEAR, LD_INIT for LOAD or STORE_LOAD.
REQ-024 SHALL sequence ST_RST->ST_INIT->ST_WAIT unconditionally, one cycle each.
REQ-025 SHALL leave ST_WAIT when str_fin_store==1: to IDLE for STORE, to CLR_LD for STORE_LOAD.
REQ-026 SHALL leave LD_WAIT to IDLE on the first cycle with ld_tvalid & ld_tready & ld_tlast.
REQ-027 SHALL load the timeout counter from the latched value on entry to ST_WAIT and to LD_WAIT.
REQ-028 SHALL, in a wait state with nonzero timeout and no completion, decrement the counter; if it equals 1, set err_timeout and go IDLE (exactly cmd_timeout wait cycles without completion).
REQ-029 SHALL give completion priority over timeout expiry in the same cycle.
REQ-030 SHALL pulse done for one cycle in the first IDLE cycle after any command ends (success or timeout).
REQ-031 SHALL clear err_timeout on the next command acceptance only.
REQ-032 SHALL increment op_count (mod 256) only on successful completion.
REQ-033 SHALL clear wait_cycles on acceptance and increment it, saturating at all-ones, in every ST_WAIT/LD_WAIT cycle.
REQ-034 SHALL NOT abort the streamer on timeout; streamer recovery after a timeout requires reset.

Reset
REQ-035 SHALL, on reset low at any time including mid-command, force state IDLE and all outputs to 0 except cmd_ready=1; op_count, wait_cycles, err_timeout=0.
REQ-036 SHALL not accept a command in the cycle reset is deasserted if reset is still low at that edge.

Verification
REQ-037 STORE, timeout 0, fin_store at 5th ST_WAIT cycle -> store_reset at T+1, store_init at T+2, IDLE and done at T+8, op_count=1, wait_cycles=5.
REQ-038 LOAD, ld_tlast handshake after 3 beats -> load_reset at T+1, load_init at T+2, done 1 cycle after last beat, store strobes never high.
REQ-039 STORE_LOAD -> strobe order store_reset, store_init, load_reset, load_init; single done; op_count +1.
REQ-040 STORE, timeout 4, fin_store never -> err_timeout=1 and done after 4 ST_WAIT cycles, op_count unchanged; next CLEAR clears err_timeout.
REQ-041 fin_store rises on the cycle the counter equals 1 -> success, err_timeout stays 0.
REQ-042 reset asserted in LD_WAIT -> immediate IDLE, all strobes 0, cmd_ready=1, counters 0.
